// File: rtl/wdata_router_pkg.sv
// Shared types and defaults for the write-data ID router.
// Slot fields are sized for the widest supported configuration;
// instances compare and store the zero-extended values.
package wdata_router_pkg;

    localparam int ID_W_DEF   = 4;
    localparam int IDX_W_DEF  = 2;
    localparam int DATA_W_DEF = 32;
    localparam int SLOTS_DEF  = 3;
    localparam int DEPTH_DEF  = 8;

    // Widest master-local ID and widest rank (SLOTS <= 8) a slot can hold.
    localparam int MAX_ID_W   = 32;
    localparam int MAX_RANK_W = 3;

    typedef logic [MAX_ID_W-1:0]   wid_t;
    typedef logic [MAX_RANK_W-1:0] rank_t;

    // One ID slot: open while valid && !done; rank orders same-ID slots.
    typedef struct packed {
        logic  valid;
        logic  done;
        wid_t  wid;
        rank_t rank;
    } slot_t;

    // Bits needed for a rank in 0..slots-1.
    function automatic int rank_w(input int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

endpackage

// File: rtl/wdata_slot_fifo.sv
// Per-slot beat FIFO: push/pop handshake, synchronous clear, pointers
// with an extra wrap bit to tell full from empty.
module wdata_slot_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the head entry this cycle, so a push at full is still safe.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Storage write.
    // NOTE: the array has no reset; stale entries are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Pointer update; reset and clear both empty the FIFO.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/wdata_id_router.sv
// Routes upstream W beats into per-ID slots, keeps same-ID bursts in
// arrival order via a rank, and frees slots on matching B responses.
// Optional invalidation flush: define WDATA_ID_ROUTER_FLUSH_EN.
module wdata_id_router
    import wdata_router_pkg::*;
#(
    parameter int ID_W   = ID_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SLOTS  = SLOTS_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [IDX_W-1:0]                 s_axi_index,
    input  logic [ID_W-1:0]                  s_axi_w_wid,
    input  logic [DATA_W-1:0]                s_axi_w_wdata,
    input  logic [DATA_W/8-1:0]              s_axi_w_wstrb,
    input  logic                             s_axi_w_wlast,
    input  logic                             s_axi_w_valid,
    output logic                             s_axi_w_ready,
    output logic [SLOTS*(IDX_W+ID_W)-1:0]    m_axi_w_wid,
    output logic [SLOTS*DATA_W-1:0]          m_axi_w_wdata,
    output logic [SLOTS*DATA_W/8-1:0]        m_axi_w_wstrb,
    output logic [SLOTS-1:0]                 m_axi_w_wlast,
    output logic [SLOTS-1:0]                 m_axi_w_valid,
    input  logic [SLOTS-1:0]                 m_axi_w_ready,
    input  logic [ID_W-1:0]                  s_axi_b_bid,
    input  logic                             s_axi_b_valid,
    input  logic                             s_axi_b_ready,
    input  logic                             inv_valid,
    input  logic [ID_W-1:0]                  inv_id,
    output logic                             flush_valid,
    output logic [ID_W-1:0]                  flush_wid,
    output logic [SLOTS*rank_w(SLOTS)-1:0]   slot_rank
);

    localparam int RW = rank_w(SLOTS);
    localparam int OW = IDX_W + ID_W;
    localparam int SW = DATA_W / 8;
    localparam int FW = DATA_W + SW + 1;
    localparam int IW = $clog2(SLOTS);

    typedef logic [IW-1:0] idx_t;

    slot_t            slot_q [SLOTS];
    slot_t            slot_d [SLOTS];
    logic [SLOTS-1:0] push, pop, clr, full, empty, removed;
    logic [FW-1:0]    fifo_out [SLOTS];

    wid_t  in_wid, b_wid;
    logic  w_hs, b_hs;
    logic  match_any, free_any, rel_any, rel_go, fl_any;
    idx_t  match_idx, free_idx, rel_idx, fl_idx;
    rank_t new_rank;

    assign in_wid = wid_t'(s_axi_w_wid);
    assign b_wid  = wid_t'(s_axi_b_bid);
    assign b_hs   = s_axi_b_valid && s_axi_b_ready;
    assign w_hs   = s_axi_w_valid && s_axi_w_ready;

    // Slot lookups: open match, lowest free slot, releasable slot (lowest index wins).
    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        free_any  = 1'b0;
        free_idx  = '0;
        rel_any   = 1'b0;
        rel_idx   = '0;
        for (int k = SLOTS-1; k >= 0; k--) begin
            if (slot_q[k].valid && !slot_q[k].done && slot_q[k].wid == in_wid) begin
                match_any = 1'b1;
                match_idx = idx_t'(k);
            end
            if (!slot_q[k].valid) begin
                free_any = 1'b1;
                free_idx = idx_t'(k);
            end
            if (b_hs && slot_q[k].valid && slot_q[k].done && slot_q[k].wid == b_wid &&
                slot_q[k].rank == '0 && empty[k]) begin
                rel_any = 1'b1;
                rel_idx = idx_t'(k);
            end
        end
    end

`ifdef WDATA_ID_ROUTER_FLUSH_EN
    // Invalidation lookup: lowest-index done slot holding inv_id.
    always_comb begin
        fl_any = 1'b0;
        fl_idx = '0;
        for (int k = SLOTS-1; k >= 0; k--) begin
            if (inv_valid && slot_q[k].valid && slot_q[k].done &&
                slot_q[k].wid == wid_t'(inv_id)) begin
                fl_any = 1'b1;
                fl_idx = idx_t'(k);
            end
        end
    end

    // Flush notice, one cycle after the invalidation request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_valid <= 1'b0;
            flush_wid   <= '0;
        end else begin
            flush_valid <= fl_any;
            flush_wid   <= fl_any ? inv_id : '0;
        end
    end
`else
    logic unused_inv;
    assign unused_inv  = ^{inv_valid, inv_id};
    assign fl_any      = 1'b0;
    assign fl_idx      = '0;
    assign flush_valid = 1'b0;
    assign flush_wid   = '0;
`endif

    // A flush and a release aimed at the same slot remove it only once.
    assign rel_go        = rel_any && !(fl_any && fl_idx == rel_idx);
    assign s_axi_w_ready = match_any ? !full[match_idx] : free_any;

    // Per-slot FIFO controls and the set of slots leaving this cycle.
    always_comb begin
        for (int k = 0; k < SLOTS; k++) begin
            clr[k]     = fl_any && fl_idx == idx_t'(k);
            removed[k] = clr[k] || (rel_go && rel_idx == idx_t'(k));
            push[k]    = w_hs && (match_any ? match_idx == idx_t'(k) : free_idx == idx_t'(k));
            pop[k]     = m_axi_w_valid[k] && m_axi_w_ready[k];
        end
    end

    // Next slot state: removals, rank shifts, then allocation or done marking.
    always_comb begin
        new_rank = '0;
        for (int j = 0; j < SLOTS; j++) begin
            if (slot_q[j].valid && slot_q[j].done && slot_q[j].wid == in_wid && !removed[j])
                new_rank = new_rank + rank_t'(1);
        end
        for (int k = 0; k < SLOTS; k++) begin
            slot_d[k] = slot_q[k];
            if (removed[k]) begin
                slot_d[k] = '0;
            end else if (slot_q[k].valid) begin
                if (rel_go && slot_q[k].wid == b_wid && slot_q[k].rank != '0)
                    slot_d[k].rank = slot_d[k].rank - rank_t'(1);
                if (fl_any && slot_q[k].wid == slot_q[fl_idx].wid &&
                    slot_q[k].rank > slot_q[fl_idx].rank)
                    slot_d[k].rank = slot_d[k].rank - rank_t'(1);
            end
        end
        if (w_hs) begin
            if (match_any) begin
                if (s_axi_w_wlast) slot_d[match_idx].done = 1'b1;
            end else begin
                slot_d[free_idx] = '{valid: 1'b1, done: s_axi_w_wlast, wid: in_wid, rank: new_rank};
            end
        end
    end

    // Slot state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SLOTS; k++) slot_q[k] <= '0;
        end else begin
            for (int k = 0; k < SLOTS; k++) slot_q[k] <= slot_d[k];
        end
    end

    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        wdata_slot_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr[k]),
            .push  (push[k]),
            .wdata ({s_axi_w_wlast, s_axi_w_wstrb, s_axi_w_wdata}),
            .pop   (pop[k]),
            .rdata (fifo_out[k]),
            .full  (full[k]),
            .empty (empty[k])
        );

        assign m_axi_w_valid[k]              = !empty[k] && slot_q[k].valid && slot_q[k].rank == '0;
        assign m_axi_w_wid[k*OW +: OW]       = {s_axi_index, slot_q[k].wid[ID_W-1:0]};
        assign m_axi_w_wdata[k*DATA_W +: DATA_W] = fifo_out[k][DATA_W-1:0];
        assign m_axi_w_wstrb[k*SW +: SW]     = fifo_out[k][DATA_W +: SW];
        assign m_axi_w_wlast[k]              = fifo_out[k][FW-1];
        assign slot_rank[k*RW +: RW]         = slot_q[k].rank[RW-1:0];
    end

endmodule

// File: tb/tb_wdata_id_router.sv
// Self-checking bench for wdata_id_router: directed scenarios plus random
// traffic, checked every cycle against a queue-based reference model.
// Honours WDATA_ID_ROUTER_FLUSH_EN the same way as the design.
module tb_wdata_id_router;

    localparam int ID_W = 4, IDX_W = 2, DATA_W = 32, SLOTS = 3, DEPTH = 8;
    localparam int RW = 2, OW = IDX_W + ID_W, SW = DATA_W / 8, FW = DATA_W + SW + 1;
    localparam int NID = 1 << ID_W;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [IDX_W-1:0]          s_axi_index;
    logic [ID_W-1:0]           s_axi_w_wid;
    logic [DATA_W-1:0]         s_axi_w_wdata;
    logic [SW-1:0]             s_axi_w_wstrb;
    logic                      s_axi_w_wlast, s_axi_w_valid, s_axi_w_ready;
    logic [SLOTS*OW-1:0]       m_axi_w_wid;
    logic [SLOTS*DATA_W-1:0]   m_axi_w_wdata;
    logic [SLOTS*SW-1:0]       m_axi_w_wstrb;
    logic [SLOTS-1:0]          m_axi_w_wlast, m_axi_w_valid, m_axi_w_ready;
    logic [ID_W-1:0]           s_axi_b_bid;
    logic                      s_axi_b_valid, s_axi_b_ready;
    logic                      inv_valid;
    logic [ID_W-1:0]           inv_id;
    logic                      flush_valid;
    logic [ID_W-1:0]           flush_wid;
    logic [SLOTS*RW-1:0]       slot_rank;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    wdata_id_router #(.ID_W(ID_W), .IDX_W(IDX_W), .DATA_W(DATA_W), .SLOTS(SLOTS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .s_axi_index(s_axi_index),
        .s_axi_w_wid(s_axi_w_wid), .s_axi_w_wdata(s_axi_w_wdata), .s_axi_w_wstrb(s_axi_w_wstrb),
        .s_axi_w_wlast(s_axi_w_wlast), .s_axi_w_valid(s_axi_w_valid), .s_axi_w_ready(s_axi_w_ready),
        .m_axi_w_wid(m_axi_w_wid), .m_axi_w_wdata(m_axi_w_wdata), .m_axi_w_wstrb(m_axi_w_wstrb),
        .m_axi_w_wlast(m_axi_w_wlast), .m_axi_w_valid(m_axi_w_valid), .m_axi_w_ready(m_axi_w_ready),
        .s_axi_b_bid(s_axi_b_bid), .s_axi_b_valid(s_axi_b_valid), .s_axi_b_ready(s_axi_b_ready),
        .inv_valid(inv_valid), .inv_id(inv_id), .flush_valid(flush_valid), .flush_wid(flush_wid),
        .slot_rank(slot_rank)
    );

    // ---------------- reference model ----------------
    // Each slot is a flag pair plus a beat queue; rank is the slot's position
    // in the per-ID list of slots in allocation order.
    bit            md_valid [SLOTS];
    bit            md_done  [SLOTS];
    int            md_wid   [SLOTS];
    logic [FW-1:0] md_q     [SLOTS][$];
    int            order_q  [NID][$];
    bit            md_flv;
    int            md_flw;

    function automatic void model_reset();
        for (int k = 0; k < SLOTS; k++) begin
            md_valid[k] = 0; md_done[k] = 0; md_wid[k] = 0; md_q[k].delete();
        end
        for (int i = 0; i < NID; i++) order_q[i].delete();
        md_flv = 0; md_flw = 0;
    endfunction

    function automatic int rank_of(int k);
        if (!md_valid[k]) return 0;
        for (int i = 0; i < order_q[md_wid[k]].size(); i++)
            if (order_q[md_wid[k]][i] == k) return i;
        return 0;
    endfunction

    function automatic int find_open(int w);
        for (int k = 0; k < SLOTS; k++)
            if (md_valid[k] && !md_done[k] && md_wid[k] == w) return k;
        return -1;
    endfunction

    function automatic int find_free();
        for (int k = 0; k < SLOTS; k++) if (!md_valid[k]) return k;
        return -1;
    endfunction

    function automatic bit exp_ready();
        int o = find_open(int'(s_axi_w_wid));
        if (o >= 0) return md_q[o].size() < DEPTH;
        return find_free() >= 0;
    endfunction

    function automatic bit exp_mv(int k);
        return md_valid[k] && md_q[k].size() > 0 && rank_of(k) == 0;
    endfunction

    function automatic void drop_slot(int k);
        int w = md_wid[k];
        for (int i = 0; i < order_q[w].size(); i++)
            if (order_q[w][i] == k) begin order_q[w].delete(i); break; end
        md_valid[k] = 0; md_done[k] = 0; md_wid[k] = 0; md_q[k].delete();
    endfunction

    // Advance the model across one rising edge using the current inputs.
    function automatic void model_edge();
        bit acc;
        int o, f, rel, fl, bid, w;
        bit popk [SLOTS];
        if (!rst_n) begin model_reset(); return; end
        w   = int'(s_axi_w_wid);
        acc = s_axi_w_valid && exp_ready();
        o   = find_open(w);
        f   = find_free();
        for (int k = 0; k < SLOTS; k++) popk[k] = exp_mv(k) && m_axi_w_ready[k];
        rel = -1;
        bid = int'(s_axi_b_bid);
        if (s_axi_b_valid && s_axi_b_ready && order_q[bid].size() > 0) begin
            int h = order_q[bid][0];
            if (md_done[h] && md_q[h].size() == 0) rel = h;
        end
        fl = -1;
`ifdef WDATA_ID_ROUTER_FLUSH_EN
        if (inv_valid)
            for (int k = SLOTS-1; k >= 0; k--)
                if (md_valid[k] && md_done[k] && md_wid[k] == int'(inv_id)) fl = k;
        md_flv = (fl >= 0);
        md_flw = (fl >= 0) ? int'(inv_id) : 0;
`endif
        for (int k = 0; k < SLOTS; k++) if (popk[k]) void'(md_q[k].pop_front());
        if (rel >= 0 && rel != fl) drop_slot(rel);
        if (fl >= 0) drop_slot(fl);
        if (acc) begin
            logic [FW-1:0] beat = {s_axi_w_wlast, s_axi_w_wstrb, s_axi_w_wdata};
            if (o >= 0) begin
                md_q[o].push_back(beat);
                if (s_axi_w_wlast) md_done[o] = 1;
            end else begin
                md_valid[f] = 1; md_done[f] = s_axi_w_wlast; md_wid[f] = w;
                order_q[w].push_back(f);
                md_q[f].push_back(beat);
            end
        end
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("w_ready", 64'(s_axi_w_ready), 64'(exp_ready()));
        for (int k = 0; k < SLOTS; k++) begin
            bit mv = exp_mv(k);
            check($sformatf("m_valid%0d", k), 64'(m_axi_w_valid[k]), 64'(mv));
            check($sformatf("rank%0d", k), 64'(slot_rank[k*RW +: RW]), 64'(rank_of(k)));
            if (mv) begin
                logic [ID_W-1:0] mw = ID_W'(md_wid[k]);
                check($sformatf("beat%0d", k),
                      64'({m_axi_w_wlast[k], m_axi_w_wstrb[k*SW +: SW], m_axi_w_wdata[k*DATA_W +: DATA_W]}),
                      64'(md_q[k][0]));
                check($sformatf("m_wid%0d", k), 64'(m_axi_w_wid[k*OW +: OW]), 64'({s_axi_index, mw}));
            end
        end
        check("flush_valid", 64'(flush_valid), 64'(md_flv));
        check("flush_wid", 64'(flush_wid), 64'(md_flw));
    endtask

    // Inputs are driven 1 after the edge; outputs are compared mid-cycle.
    task automatic step();
        #4;
        compare_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int id, input int data, input bit last);
        s_axi_w_valid = 1'b1;
        s_axi_w_wid   = ID_W'(id);
        s_axi_w_wdata = DATA_W'(data);
        s_axi_w_wstrb = '1;
        s_axi_w_wlast = last;
        step();
        s_axi_w_valid = 1'b0;
    endtask

    task automatic bresp(input int id);
        s_axi_b_valid = 1'b1;
        s_axi_b_bid   = ID_W'(id);
        step();
        s_axi_b_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; s_axi_index = 2'd2;
        s_axi_w_valid = 0; s_axi_w_wid = '0; s_axi_w_wdata = '0; s_axi_w_wstrb = '0; s_axi_w_wlast = 0;
        m_axi_w_ready = '0; s_axi_b_bid = '0; s_axi_b_valid = 0; s_axi_b_ready = 1;
        inv_valid = 0; inv_id = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_ready", 64'(s_axi_w_ready), 64'd1);
        check("rst_mvalid", 64'(m_axi_w_valid), 64'd0);
        check("rst_rank", 64'(slot_rank), 64'd0);
        check("rst_flush", 64'({flush_valid, flush_wid}), 64'd0);

        // ID 3 burst of four beats into slot 0.
        m_axi_w_ready = '1;
        for (int i = 0; i < 4; i++) begin
            beat(3, 32'hA0 + i, i == 3);
            if (i == 0) begin
                check("first_valid", 64'(m_axi_w_valid[0]), 64'd1);
                check("first_data", 64'(m_axi_w_wdata[7:0]), 64'hA0);
            end
        end
        idle(3);
        bresp(3);

        // Interleaved ID 1 / ID 2 bursts go to separate slots.
        for (int i = 0; i < 8; i++) begin
            beat((i % 2) ? 2 : 1, 32'h100 + i, i >= 6);
            if (i == 1) check("ilv_wid1", 64'(m_axi_w_wid[OW +: OW]), 64'({2'd2, 4'd2}));
        end
        idle(3);
        bresp(1);
        bresp(2);

        // Two back-to-back ID 5 bursts: the second waits behind the first.
        m_axi_w_ready = '0;
        for (int i = 0; i < 4; i++) beat(5, 32'h500 + i, i % 2 == 1);
        m_axi_w_ready = '1;
        check("same_id_rank", 64'(slot_rank[RW +: RW]), 64'd1);
        check("same_id_hold", 64'(m_axi_w_valid[1]), 64'd0);
        idle(3);
        check("same_id_hold2", 64'(m_axi_w_valid[1]), 64'd0);
        bresp(5);
        check("same_id_rank0", 64'(slot_rank[RW +: RW]), 64'd0);
        check("same_id_go", 64'(m_axi_w_valid[1]), 64'd1);
        idle(3);
        bresp(5);

        // Full FIFO back-pressure on slot 0.
        m_axi_w_ready = '0;
        for (int i = 0; i < 8; i++) beat(4, 32'h400 + i, 1'b0);
        s_axi_w_valid = 1'b1; s_axi_w_wid = 4'd4; s_axi_w_wdata = 32'h408; s_axi_w_wlast = 1'b1;
        check("full_ready", 64'(s_axi_w_ready), 64'd0);
        step();
        m_axi_w_ready = 3'b001;
        step();
        m_axi_w_ready = '0;
        check("full_recover", 64'(s_axi_w_ready), 64'd1);
        step();
        s_axi_w_valid = 1'b0;
        m_axi_w_ready = '1;
        idle(10);
        bresp(4);

        // Invalidation of a done ID 6 slot.
        m_axi_w_ready = '0;
        beat(6, 32'h600, 1'b0);
        beat(6, 32'h601, 1'b1);
        inv_valid = 1'b1; inv_id = 4'd6;
        step();
        inv_valid = 1'b0;
`ifdef WDATA_ID_ROUTER_FLUSH_EN
        check("inv_flush", 64'({flush_valid, flush_wid}), 64'({1'b1, 4'd6}));
        check("inv_empty", 64'(m_axi_w_valid), 64'd0);
`else
        check("inv_flush", 64'({flush_valid, flush_wid}), 64'd0);
        check("inv_kept", 64'(m_axi_w_valid[0]), 64'd1);
`endif
        m_axi_w_ready = '1;
        idle(3);
        bresp(6);

        // Reset in the middle of a burst.
        m_axi_w_ready = '0;
        beat(7, 32'h700, 1'b0);
        beat(7, 32'h701, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_mvalid", 64'(m_axi_w_valid), 64'd0);
        check("mid_rst_ready", 64'(s_axi_w_ready), 64'd1);
        check("mid_rst_rank", 64'(slot_rank), 64'd0);
        beat(7, 32'h7F0, 1'b1);
        check("mid_rst_slot0", 64'(m_axi_w_valid[0]), 64'd1);
        m_axi_w_ready = '1;
        idle(2);
        bresp(7);

        // Random traffic over a small ID set to force same-ID ordering.
        for (int c = 0; c < 3000; c++) begin
            rst_n         = ($urandom_range(0, 999) != 0);
            s_axi_index   = IDX_W'($urandom);
            s_axi_w_valid = ($urandom_range(0, 9) < 6);
            s_axi_w_wid   = ID_W'($urandom_range(0, 3));
            s_axi_w_wdata = DATA_W'($urandom);
            s_axi_w_wstrb = SW'($urandom);
            s_axi_w_wlast = ($urandom_range(0, 9) < 3);
            m_axi_w_ready = SLOTS'($urandom);
            s_axi_b_valid = ($urandom_range(0, 3) == 0);
            s_axi_b_bid   = ID_W'($urandom_range(0, 3));
            s_axi_b_ready = ($urandom_range(0, 4) != 0);
            inv_valid     = ($urandom_range(0, 19) == 0);
            inv_id        = ID_W'($urandom_range(0, 3));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/wdata_id_router.md
WDATA_ID_ROUTER -- requirements
Module: wdata_id_router

Interface
REQ-001 Parameter ID_W, default 4, master-local write ID width.
REQ-002 Parameter IDX_W, default 2, master index width prepended to output IDs.
REQ-003 Parameter DATA_W, default 32, data width; strobe width is DATA_W/8.
REQ-004 Parameter SLOTS, default 3, number of ID slots and per-slot FIFOs (2..8).
REQ-005 Parameter DEPTH, default 8, per-slot FIFO depth (power of two, >=2).
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 s_axi_index  in  IDX_W  master number.
REQ-009 s_axi_w_wid/wdata/wstrb/wlast/valid  in  ID_W/DATA_W/DATA_W/8/1/1  upstream W beat; s_axi_w_ready out 1.
REQ-010 m_axi_w_wid  out  SLOTS*(IDX_W+ID_W)  per-slot {s_axi_index, slot ID}, slot k at LSB slice k.
REQ-011 m_axi_w_wdata/wstrb/wlast/valid  out  SLOTS*DATA_W / SLOTS*DATA_W/8 / SLOTS / SLOTS  per-slot FIFO head; m_axi_w_ready in SLOTS.
REQ-012 s_axi_b_bid/valid/ready  in  ID_W/1/1  merged B channel as returned to the master (monitored only).
REQ-013 inv_valid/inv_id  in  1/ID_W  invalidation request from the address arbiter.
REQ-014 flush_valid/flush_wid  out  1/ID_W  flush notice to write-response logic.
REQ-015 slot_rank  out  SLOTS*$clog2(SLOTS)  same-ID ordering rank per slot.

Function
REQ-016 Slot state: valid, wid, done, rank; slot "open" = valid && !done.
REQ-017 Beat with wid equal to an open slot's wid routes to that slot; at most one open slot per wid.
REQ-018 Beat with no open match allocates the lowest-index invalid slot: valid=1, wid latched, done=0, rank = number of valid done slots with the same wid.
REQ-019 s_axi_w_ready = (open match && that FIFO not full) || (no match && free slot exists); combinational, no dependency on s_axi_w_valid.
REQ-020 Accepted beat is written into the FIFO in the acceptance cycle; earliest m_axi_w_valid is the following cycle; no beat is ever dropped.
REQ-021 Handshake with wlast=1 sets the slot's done bit.
REQ-022 m_axi_w_valid[k] = FIFO k not empty && valid[k] && rank[k]==0; same-ID data leaves strictly in arrival order.
REQ-023 B handshake with bid releases the slot with valid, done, wid==bid, rank==0, FIFO empty; every other valid slot with that wid decrements rank.
REQ-024 B handshake matching no releasable slot changes no state.
REQ-025 Slot released in a cycle is not allocatable until the next cycle; allocation and release in the same cycle both take effect.
REQ-026 FIFO full with matched beat: ready low, slot state unchanged; all slots valid and no match: ready low.
REQ-027 FIFO pointers wrap modulo DEPTH; full/empty by extra pointer bit; simultaneous push/pop at full or empty keeps occupancy correct.

Reset
REQ-028 With rst_n low at a clock edge: all slots invalid, done/rank/wid zero, FIFOs empty, m_axi_w_valid=0, flush_valid=0, flush_wid=0, s_axi_w_ready reflects free slots (1).
REQ-029 Reset mid-burst discards all buffered beats; no partial beat survives.

Configuration
REQ-030 Macro WDATA_ID_ROUTER_FLUSH_EN defined: inv_valid with inv_id equal to a valid done slot's wid (lowest index if several) empties that FIFO, frees the slot, decrements same-ID younger ranks, pulses flush_valid one cycle with flush_wid=inv_id, all registered one cycle after inv_valid.
REQ-031 Macro undefined: inv_valid/inv_id ignored; flush_valid and flush_wid held 0.

Structure
REQ-032 Package wdata_router_pkg holds slot-state struct typedef, rank width function and default parameter constants.
REQ-033 One sub-module wdata_slot_fifo (parametrised WIDTH/DEPTH, push/pop handshake, synchronous clear) instantiated SLOTS times.

Verification
REQ-034 ID 3 4-beat burst, all ready high -> slot 0, beats 0xA0..0xA3 on slot 0 in order, first m valid one cycle after first accept.
REQ-035 Interleave ID 1 and ID 2 beats -> slot 0 receives only ID 1, slot 1 only ID 2, output wid {index,1}/{index,2}.
REQ-036 Two complete ID 5 bursts back-to-back -> slot 1 rank 1, slot 1 valid held 0 until B bid=5 releases slot 0, then rank 0.
REQ-037 m_axi_w_ready[0]=0, push 9 beats ID 4 at DEPTH=8 -> ready drops after 8th accept, recovers one cycle after a pop.
REQ-038 FLUSH_EN, done ID 6 slot, inv_valid inv_id=6 -> FIFO empty, slot free, flush_valid one cycle with flush_wid=6; macro off -> no effect.
REQ-039 Assert rst_n low during burst -> all outputs at reset values next cycle, new burst allocates slot 0.
